// File: rtl/axi_pkg.sv
// AXI4 encodings and the R-beat record shared by the read responder and the fetch master.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
  localparam logic [1:0] AXI_BURST_RSVD  = 2'b11;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [2:0] AXI_SIZE_8B     = 3'd3;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_beat_t;

  // WRAP bursts are legal only with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next beat address for 8-byte AXI bursts; FIXED and reserved hold the address.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] mask;

  always_comb begin
    incr = addr + ADDR_WIDTH'(8);
    // (len+1)*8 - 1 equals len*8 + 7 since the low three bits of len*8 are zero
    mask = (ADDR_WIDTH'(len) << 3) | ADDR_WIDTH'(7);
    case (burst)
      AXI_BURST_INCR: next_addr = incr;
      AXI_BURST_WRAP: next_addr = (addr & ~mask) | (incr & mask);
      default:        next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read responder: one outstanding INCR/WRAP burst of 64-bit beats from a
// synchronous-read SRAM, with a 2-entry R buffer absorbing backpressure.
//
//   state | meaning
//   IDLE  | arready high, waiting for an AR handshake
//   BURST | issuing SRAM reads and returning beats, arready low
module axi_rd_responder
  import axi_pkg::*;
#(
  parameter int                    ID_WIDTH   = 13,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MEM_AW     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  mem_en,
  output logic [MEM_AW-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic {IDLE, BURST} state_t;
  typedef logic [ADDR_WIDTH:0] ext_t;

  localparam ext_t MEM_LIMIT = ext_t'(BASE_ADDR) + (ext_t'(1) << (MEM_AW + 3));

  state_t                state;
  logic                  arready_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [1:0]            burst_q;
  logic                  err_q;
  logic [8:0]            issue_cnt;
  logic                  pend;
  logic                  pend_last;
  logic                  pend_err;
  r_beat_t               fifo [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;

  logic                  ar_hs;
  logic                  ar_err;
  logic [ADDR_WIDTH-1:0] ar_start;
  logic [ADDR_WIDTH-1:0] ar_mask;
  logic [ADDR_WIDTH-1:0] ar_low;
  ext_t                  ar_high;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] next_addr;
  r_beat_t               src;
  r_beat_t               out;
  logic                  rvalid;
  logic                  pop;
  logic                  fifo_pop;
  logic                  push;
  logic                  last_hs;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .addr      (addr_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // The whole burst footprint is checked up front so an error burst never touches the SRAM.
  always_comb begin
    ar_hs    = s_axi_arvalid & arready_q;
    ar_start = s_axi_araddr & ~ADDR_WIDTH'(7);
    ar_mask  = (ADDR_WIDTH'(s_axi_arlen) << 3) | ADDR_WIDTH'(7);
    ar_low   = (s_axi_arburst == AXI_BURST_WRAP) ? (ar_start & ~ar_mask) : ar_start;
    ar_high  = ext_t'(ar_low) + ext_t'({s_axi_arlen, 3'b000});
    ar_err   = (s_axi_arsize != AXI_SIZE_8B)
             | (s_axi_arburst == AXI_BURST_FIXED)
             | (s_axi_arburst == AXI_BURST_RSVD)
             | ((s_axi_arburst == AXI_BURST_WRAP) & ~wrap_len_ok(s_axi_arlen))
             | (ext_t'(ar_low) < ext_t'(BASE_ADDR))
             | (ar_high >= MEM_LIMIT);
  end

  // Error bursts still run the issue pipeline so beat pacing is identical, but mem_en stays low.
  always_comb begin
    issue    = (state == BURST) & (issue_cnt <= {1'b0, len_q}) & ((count + {1'b0, pend}) < 2'd2);
    mem_en   = issue & ~err_q;
    mem_addr = mem_en ? MEM_AW'((addr_q - BASE_ADDR) >> 3) : '0;
  end

  // An empty buffer passes the returning SRAM word straight through to R.
  always_comb begin
    src.data = pend_err ? '0 : 64'(mem_rdata);
    src.resp = pend_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    src.last = pend_last;
    if (count != 2'd0) out = fifo[rd_ptr];
    else if (pend)     out = src;
    else               out = '0;
    rvalid   = (count != 2'd0) | pend;
    pop      = rvalid & s_axi_rready;
    fifo_pop = pop & (count != 2'd0);
    push     = pend & ~((count == 2'd0) & s_axi_rready);
    last_hs  = pop & out.last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      arready_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      issue_cnt <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      pend_err  <= 1'b0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= '0;
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
    end else begin
      pend      <= issue;
      pend_last <= issue & (issue_cnt == {1'b0, len_q});
      pend_err  <= err_q;
      if (issue) begin
        addr_q    <= next_addr;
        issue_cnt <= issue_cnt + 9'd1;
      end
      if (push) begin
        fifo[wr_ptr] <= src;
        wr_ptr       <= ~wr_ptr;
      end
      if (fifo_pop) rd_ptr <= ~rd_ptr;
      case ({push, fifo_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      case (state)
        IDLE: begin
          if (ar_hs) begin
            state     <= BURST;
            arready_q <= 1'b0;
            id_q      <= s_axi_arid;
            addr_q    <= ar_start;
            len_q     <= s_axi_arlen;
            burst_q   <= s_axi_arburst;
            err_q     <= ar_err;
            issue_cnt <= '0;
          end else begin
            arready_q <= 1'b1;
          end
        end
        BURST: begin
          if (last_hs) begin
            state     <= IDLE;
            arready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rid     = id_q;
  assign s_axi_rdata   = DATA_WIDTH'(out.data);
  assign s_axi_rresp   = out.resp;
  assign s_axi_rlast   = out.last;
  assign s_axi_rvalid  = rvalid;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Bench for axi_rd_responder: directed and random bursts against a burst-level address/response model.
module tb_axi_rd_responder;

  localparam int             IDW       = 13;
  localparam int             AW        = 64;
  localparam int             DW        = 64;
  localparam int             MAW       = 16;
  localparam logic [63:0]    BASE      = 64'h0;
  localparam longint unsigned MEM_BYTES = longint'(1) << (MAW + 3);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [IDW-1:0]  arid = '0;
  logic [AW-1:0]   araddr = '0;
  logic [7:0]      arlen = '0;
  logic [2:0]      arsize = '0;
  logic [1:0]      arburst = '0;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [IDW-1:0]  rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready = 1'b0;
  logic            mem_en;
  logic [MAW-1:0]  mem_addr;
  logic [DW-1:0]   mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_data[$];
  logic [1:0]  exp_resp[$];
  logic        exp_last[$];
  logic [15:0] exp_word[$];

  always #5 clk = ~clk;

  axi_rd_responder #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .MEM_AW(MAW)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  function automatic logic [63:0] word_val(input logic [15:0] w);
    return {16'hD00D, w, ~w, 16'h1234};
  endfunction

  always @(posedge clk) if (mem_en) mem_rdata <= word_val(mem_addr);

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Burst-level model: beat addresses from modular arithmetic, error if any rule or beat range fails.
  function automatic bit model(input logic [63:0] addr, input int len, input int size, input int burst);
    longint unsigned start, nbytes, region, a;
    logic [15:0] w;
    bit err;
    start  = addr - (addr % 8);
    nbytes = longint'(len + 1) * 8;
    region = start - (start % nbytes);
    err = (size != 3) || (burst == 0) || (burst == 3) ||
          (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    exp_data.delete(); exp_resp.delete(); exp_last.delete(); exp_word.delete();
    for (int i = 0; i <= len; i++) begin
      if (burst == 2) a = region + ((start - region + longint'(i) * 8) % nbytes);
      else            a = start + longint'(i) * 8;
      if (a < BASE || a >= BASE + MEM_BYTES) err = 1;
      exp_word.push_back(16'((a - BASE) >> 3));
    end
    for (int i = 0; i <= len; i++) begin
      exp_data.push_back(err ? 64'h0 : word_val(exp_word[i]));
      exp_resp.push_back(err ? 2'b10 : 2'b00);
      exp_last.push_back(i == len);
    end
    return err;
  endfunction

  function automatic logic rsel(input int mode, input int c);
    int pat[7];
    pat = '{1, 0, 0, 1, 1, 0, 1};
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c < 7) ? logic'(pat[c]) : 1'b1;
    return logic'($urandom_range(0, 1));
  endfunction

  // Protocol monitor: R payload held while stalled; no read issued with 2 OKAY beats outstanding.
  int   outstanding = 0;
  bit   stalled = 0;
  bit   rst_at_edge = 1;
  logic [IDW+DW+2:0] held = '0;

  always @(posedge clk) begin
    rst_at_edge <= reset;
    if (reset) outstanding <= 0;
    else outstanding <= outstanding + int'(mem_en) - int'(rvalid && rready && rresp == 2'b00);
  end

  always @(negedge clk) begin
    if (!rst_at_edge) begin
      if (stalled) chk("r_stable", {rvalid, rid, rdata, rresp, rlast}, {1'b1, held});
      if (mem_en)  chk("issue_limit", outstanding < 2, 1'b1);
    end
    stalled = !reset && rvalid && !rready;
    held    = {rid, rdata, rresp, rlast};
  end

  task automatic run_burst(input logic [IDW-1:0] id, input logic [63:0] addr, input int len,
                           input int size, input int burst, input int rmode, input int reset_at,
                           input string tag);
    bit err, arhs, done;
    int nbeat, nissue, first_c, last_c;
    err = model(addr, len, size, burst);
    @(posedge clk); #1;
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1;
    arhs = 0;
    for (int k = 0; k < 20 && !arhs; k++) begin
      @(negedge clk);
      if (arready) arhs = 1;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    chk({tag, " ar_hs"}, arhs, 1'b1);
    if (!arhs) return;
    nbeat = 0; nissue = 0; first_c = -1; last_c = -1; done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      rready = rsel(rmode, c);
      @(negedge clk);
      if (mem_en) begin
        if (!err && nissue <= len) chk({tag, " mem_addr"}, mem_addr, exp_word[nissue]);
        nissue++;
      end
      if (rvalid && first_c < 0) first_c = c;
      if (reset_at >= 0 && rvalid && nbeat == reset_at) begin
        reset = 1'b1;
        done = 1;
      end else if (rvalid && rready) begin
        if (nbeat <= len) begin
          chk({tag, " rdata"}, rdata, exp_data[nbeat]);
          chk({tag, " rid/rresp/rlast"}, {rid, rresp, rlast}, {id, exp_resp[nbeat], exp_last[nbeat]});
        end
        if (rlast) begin
          done = 1;
          last_c = c;
        end
        nbeat++;
      end
      @(posedge clk); #1;
    end
    chk({tag, " completed"}, done, 1'b1);
    if (reset_at >= 0) begin
      @(negedge clk);
      chk({tag, " outs after reset"}, {rvalid, mem_en, arready, rlast, rresp, rdata}, '0);
      reset = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " arready after reset"}, arready, 1'b1);
    end else begin
      chk({tag, " beats"}, nbeat, len + 1);
      chk({tag, " reads"}, nissue, err ? 0 : len + 1);
      if (rmode == 0) begin
        chk({tag, " first beat latency"}, first_c, 1);
        chk({tag, " last beat cycle"}, last_c, len + 1);
      end
    end
  endtask

  initial begin
    logic [63:0] d_a, d_b;
    int nb, nar, r, b, l, s, m;
    int ar_c[2];
    int last_c[2];
    int wl[4];
    logic [63:0] a;
    bit unused_err;

    wl = '{1, 3, 7, 15};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outs", {arready, rvalid, rlast, rresp, rdata, rid, mem_en, mem_addr}, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("arready low in release cycle", arready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("arready after release", arready, 1'b1);

    run_burst(13'h5,   64'h1010, 7, 3, 2, 0, -1, "wrap7");
    run_burst(13'h1AB, 64'h2000, 3, 3, 1, 1, -1, "incr3 stall");
    run_burst(13'h7,   64'h3000, 1, 2, 1, 0, -1, "size2 err");
    run_burst(13'h8,   64'h4000, 2, 3, 2, 0, -1, "wrap len2 err");
    run_burst(13'h9,   64'h0100, 0, 3, 0, 0, -1, "fixed err");
    run_burst(13'hA,   64'h7FFF0, 1, 3, 1, 0, -1, "top in range");
    run_burst(13'hB,   64'h7FFF8, 1, 3, 1, 0, -1, "top overrun err");
    run_burst(13'hC,   64'h0000, 0, 3, 1, 0, -1, "single beat");

    // Back-to-back: arvalid stays high across two single-beat INCR requests.
    unused_err = model(64'h6000, 0, 3, 1);
    d_a = exp_data[0];
    unused_err = model(64'h6008, 0, 3, 1);
    d_b = exp_data[0];
    @(posedge clk); #1;
    arid = 13'd11; araddr = 64'h6000; arlen = 8'd0; arsize = 3'd3; arburst = 2'd1;
    arvalid = 1'b1; rready = 1'b1;
    nb = 0; nar = 0;
    ar_c = '{-1, -1}; last_c = '{-1, -1};
    for (int c = 0; c < 40 && nb < 2; c++) begin
      @(negedge clk);
      if (nar == 1 && nb == 0) chk("b2b ar held off", arready, 1'b0);
      if (arvalid && arready && nar < 2) begin
        ar_c[nar] = c;
        nar++;
      end
      if (rvalid && rready) begin
        chk("b2b rdata", rdata, (nb == 0) ? d_a : d_b);
        chk("b2b rid/rresp/rlast", {rid, rresp, rlast}, {(nb == 0) ? 13'd11 : 13'd12, 2'b00, 1'b1});
        last_c[nb] = c;
        nb++;
      end
      @(posedge clk); #1;
      if (nar == 1 && arid == 13'd11) begin
        arid = 13'd12;
        araddr = 64'h6008;
      end
      if (nar == 2) arvalid = 1'b0;
    end
    arvalid = 1'b0;
    chk("b2b beats", nb, 2);
    chk("b2b second ar cycle", ar_c[1], last_c[0] + 1);

    run_burst(13'h3, 64'h5000, 7, 3, 1, 0, 3,  "reset mid burst");
    run_burst(13'h4, 64'h5000, 7, 3, 1, 0, -1, "after reset");

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 19);
      b = (r < 9) ? 1 : (r < 18) ? 2 : (r == 18) ? 0 : 3;
      if (b == 2) l = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : wl[$urandom_range(0, 3)];
      else        l = $urandom_range(0, 15);
      s = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : 3;
      a = 64'($urandom_range(0, 32'h80080));
      m = ($urandom_range(0, 1) == 1) ? 2 : 0;
      run_burst(13'($urandom_range(0, 8191)), a, l, s, b, m, -1, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
